// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: walks an active-low row strobe, samples the synchronized
// columns into a 16-bit snapshot, debounces whole scans and reports single keypresses.
module keypad_matrix_scanner #(
  parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
  parameter int unsigned SCAN_RATE_IN_HERTZ          = 1000,
  parameter int unsigned DEBOUNCE_SCANS              = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] io_row,
  input  logic [3:0] io_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       key_multi
);

  localparam int unsigned CYCLES_PER_ROW = BOARD_CLOCK_FREQUENCY_IN_HZ / SCAN_RATE_IN_HERTZ;
  localparam int unsigned SLOT_W         = $clog2(CYCLES_PER_ROW);
  localparam int unsigned CNT_W          = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CYCLES_PER_ROW - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(DEBOUNCE_SCANS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  logic [3:0]        col_meta_q, col_sync_q;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [1:0]        row_q, row_d;
  logic [15:0]       snap_q, snap_d;
  logic              scan_done_q, scan_done_d;
  logic [15:0]       prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept_q, accept_d;
  logic [0:0]        state_q, state_d;
  logic [3:0]        code_q, code_d;
  logic              valid_q, valid_d;
  logic              held_q, held_d;
  logic              multi_q, multi_d;
  logic              slot_last;
  logic [4:0]        pop;
  logic [3:0]        idx;

  assign io_row    = ~(4'b0001 << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign key_multi = multi_q;

  // Row slot timing and column sampling into the current row's nibble
  always_comb begin
    slot_last   = (slot_q == SLOT_LAST);
    slot_d      = slot_last ? '0 : slot_q + SLOT_W'(1);
    row_d       = slot_last ? row_q + 2'd1 : row_q;
    snap_d      = snap_q;
    if (slot_last) snap_d[{row_q, 2'b00} +: 4] = ~col_sync_q;
    scan_done_d = slot_last && (row_q == 2'd3);
  end

  // Scan-to-scan debounce; prev_q holds the snapshot being qualified
  always_comb begin
    prev_d   = prev_q;
    cnt_d    = cnt_q;
    accept_d = 1'b0;
    if (scan_done_q) begin
      if (snap_q == prev_q) begin
        if (cnt_q != CNT_MAX) begin
          cnt_d    = cnt_q + CNT_W'(1);
          accept_d = (cnt_q == CNT_PRE);
        end
      end else begin
        prev_d   = snap_q;
        cnt_d    = CNT_W'(1);
        accept_d = (DEBOUNCE_SCANS == 1);
      end
    end
  end

  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      pop = pop + {4'b0000, prev_q[i]};
      if (prev_q[i]) idx = 4'(i);
    end
  end

  // Press/release FSM; prev_q is the accepted snapshot while accept_q is high
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    multi_d = multi_q;
    if (accept_q) begin
      case (state_q)
        ST_IDLE: begin
          if (pop == 5'd1) begin
            code_d  = idx;
            valid_d = 1'b1;
            held_d  = 1'b1;
            multi_d = 1'b0;
            state_d = ST_HELD;
          end else begin
            multi_d = (pop > 5'd1);
          end
        end
        default: begin
          if (pop == 5'd0) begin
            held_d  = 1'b0;
            multi_d = 1'b0;
            state_d = ST_IDLE;
          end else begin
            multi_d = (pop > 5'd1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_q  <= 4'hF;
      col_sync_q  <= 4'hF;
      slot_q      <= '0;
      row_q       <= 2'd0;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
      prev_q      <= '0;
      cnt_q       <= '0;
      accept_q    <= 1'b0;
      state_q     <= ST_IDLE;
      code_q      <= 4'd0;
      valid_q     <= 1'b0;
      held_q      <= 1'b0;
      multi_q     <= 1'b0;
    end else begin
      col_meta_q  <= io_col;
      col_sync_q  <= col_meta_q;
      slot_q      <= slot_d;
      row_q       <= row_d;
      snap_q      <= snap_d;
      scan_done_q <= scan_done_d;
      prev_q      <= prev_d;
      cnt_q       <= cnt_d;
      accept_q    <= accept_d;
      state_q     <= state_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      held_q      <= held_d;
      multi_q     <= multi_d;
    end
  end

endmodule
